// File: rtl/min_sched_pkg.sv
// Shared types and default sizing for the frame-minimum scheduler.
package min_sched_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BEATS = 16;

  // IDLE: no frame open, ACCUM: frame open, HOLD: result pending
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/min4_lane.sv
// Combinational 4-input unsigned minimum with index of the first (lowest-lane) minimum.
module min4_lane
  import min_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] lane_a,
  input  logic [DATA_W-1:0] lane_b,
  input  logic [DATA_W-1:0] lane_c,
  input  logic [DATA_W-1:0] lane_d,
  output logic [DATA_W-1:0] min_val,
  output lane_t             min_lane
);

  logic [DATA_W-1:0] min_ab, min_cd;
  lane_t             lane_ab, lane_cd;

  // Pairwise tree; strict compares keep the lower lane on ties at every level
  always_comb begin
    min_ab  = lane_a;
    lane_ab = 2'd0;
    if (lane_b < lane_a) begin
      min_ab  = lane_b;
      lane_ab = 2'd1;
    end
    min_cd  = lane_c;
    lane_cd = 2'd2;
    if (lane_d < lane_c) begin
      min_cd  = lane_d;
      lane_cd = 2'd3;
    end
    min_val  = min_ab;
    min_lane = lane_ab;
    if (min_cd < min_ab) begin
      min_val  = min_cd;
      min_lane = lane_cd;
    end
  end

endmodule

// File: rtl/min_frame_scheduler.sv
// Frame-level minimum tracker: accepts 4-lane beats, keeps the running minimum and its
// first position, and presents one registered result per frame with full backpressure.
module min_frame_scheduler
  import min_sched_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1),
  localparam int IDX_W    = $clog2(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_d,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [IDX_W-1:0]  out_beat,
  output lane_t             out_lane,
  output logic [CNT_W-1:0]  out_beats
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [IDX_W-1:0]  run_beat_q, run_beat_d;
  lane_t             run_lane_q, run_lane_d;
  logic [DATA_W-1:0] out_min_q, out_min_d;
  logic [IDX_W-1:0]  out_beat_q, out_beat_d;
  lane_t             out_lane_q, out_lane_d;
  logic [CNT_W-1:0]  out_beats_q, out_beats_d;

  logic [DATA_W-1:0] beat_min;
  lane_t             beat_lane;
  logic              accept;
  logic              beat_first;
  logic [CNT_W-1:0]  beat_idx;
  logic [CNT_W-1:0]  cnt_new;
  logic              close;
  logic              take_beat;
  logic [DATA_W-1:0] new_min;
  logic [IDX_W-1:0]  new_beat;
  lane_t             new_lane;

  min4_lane #(.DATA_W(DATA_W)) u_min4 (
    .lane_a   (in_a),
    .lane_b   (in_b),
    .lane_c   (in_c),
    .lane_d   (in_d),
    .min_val  (beat_min),
    .min_lane (beat_lane)
  );

  // Handshake signals depend only on state and out_ready, never on in_valid
  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q != HOLD) || out_ready;
    accept    = in_valid && in_ready;
  end

  // Beat bookkeeping: a beat taken outside ACCUM opens a new frame and loads unconditionally
  always_comb begin
    beat_first = (state_q != ACCUM);
    beat_idx   = beat_first ? '0 : cnt_q;
    cnt_new    = beat_idx + CNT_W'(1);
    close      = in_last || (cnt_new == CNT_W'(MAX_BEATS));
    take_beat  = beat_first || (beat_min < run_min_q);
    new_min    = take_beat ? beat_min : run_min_q;
    new_beat   = take_beat ? beat_idx[IDX_W-1:0] : run_beat_q;
    new_lane   = take_beat ? beat_lane : run_lane_q;
  end

  // Next-state, running accumulator and output-stage update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_min_d   = run_min_q;
    run_beat_d  = run_beat_q;
    run_lane_d  = run_lane_q;
    out_min_d   = out_min_q;
    out_beat_d  = out_beat_q;
    out_lane_d  = out_lane_q;
    out_beats_d = out_beats_q;
    if (accept) begin
      run_min_d  = new_min;
      run_beat_d = new_beat;
      run_lane_d = new_lane;
      if (close) begin
        state_d     = HOLD;
        cnt_d       = '0;
        out_min_d   = new_min;
        out_beat_d  = new_beat;
        out_lane_d  = new_lane;
        out_beats_d = cnt_new;
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_new;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_min_q   <= '0;
      run_beat_q  <= '0;
      run_lane_q  <= '0;
      out_min_q   <= '0;
      out_beat_q  <= '0;
      out_lane_q  <= '0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_min_q   <= run_min_d;
      run_beat_q  <= run_beat_d;
      run_lane_q  <= run_lane_d;
      out_min_q   <= out_min_d;
      out_beat_q  <= out_beat_d;
      out_lane_q  <= out_lane_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_min   = out_min_q;
  assign out_beat  = out_beat_q;
  assign out_lane  = out_lane_q;
  assign out_beats = out_beats_q;

endmodule
